// File: rtl/stretch_pkg.sv
// Shared types and constants for the hit pulse stretcher.
// Optional build macro: STRETCH_BLINK_EN (blinking tail on level outputs).
package stretch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } lane_state_t;

  localparam int              DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

  // Saturating add for the dropped-pulse statistic; never wraps past DROP_MAX.
  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [DROP_W-1:0] b);
    logic [DROP_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, DROP_MAX}) ? DROP_MAX : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/stretch_lane.sv
// One stretcher lane: IDLE/HOLD FSM, hold down-counter, registered level and
// done strobe, plus a combinational "dropped" flag for the shared statistic.
// Optional build macro: STRETCH_BLINK_EN (level blinks in the second half of
// the hold; state, counter and done timing are identical either way).
module stretch_lane
  import stretch_pkg::*;
#(
  parameter  int HOLD_CYCLES = 8,
  localparam int CNT_W       = $clog2(HOLD_CYCLES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pulse,
  input  logic        retrig_en,
  input  logic        clear,
  output logic        level,
  output logic        done,
  output logic        dropped,
  output lane_state_t state
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF   = CNT_W'(HOLD_CYCLES / 2);

  lane_state_t      state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             level_d, done_d;

  // Next state: clear wins over everything; a pulse during HOLD either
  // reloads the counter (retrigger) or is counted as dropped.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    done_d  = 1'b0;
    dropped = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (pulse) begin
            state_d = HOLD;
            cnt_d   = RELOAD;
          end
        end
        HOLD: begin
          if (pulse && retrig_en) begin
            cnt_d = RELOAD;
          end else begin
            dropped = pulse;
            if (cnt == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
`ifdef STRETCH_BLINK_EN
    level_d = (state_d == HOLD) && ((cnt_d >= HALF) || cnt_d[0]);
`else
    level_d = (state_d == HOLD);
`endif
  end

  // Lane registers; outputs are taken straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      level <= level_d;
      done  <= done_d;
    end
  end

endmodule

// File: rtl/hit_pulse_stretcher.sv
// Stretches per-lane one-cycle hit pulses into held level outputs, with
// retrigger control, synchronous clear, completion strobes and a saturating
// dropped-pulse counter shared by all lanes.
// Optional build macro: STRETCH_BLINK_EN (blinking tail before expiry).
module hit_pulse_stretcher
  import stretch_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LANES-1:0]  pulse_in,
  input  logic              retrig_en,
  input  logic              clear,
  output logic [LANES-1:0]  level_out,
  output logic [LANES-1:0]  done_pulse,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count
);

  logic [LANES-1:0]  dropped;
  logic [LANES-1:0]  lane_hold;
  lane_state_t       lane_state [LANES];
  logic [DROP_W-1:0] drop_sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    stretch_lane #(.HOLD_CYCLES(HOLD_CYCLES)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .pulse     (pulse_in[i]),
      .retrig_en (retrig_en),
      .clear     (clear),
      .level     (level_out[i]),
      .done      (done_pulse[i]),
      .dropped   (dropped[i]),
      .state     (lane_state[i])
    );
    assign lane_hold[i] = (lane_state[i] == HOLD);
  end

  // busy is an OR of lane state flops, so it tracks HOLD even when blinking.
  assign busy = |lane_hold;

  // Count how many lanes dropped a pulse this cycle.
  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      drop_sum = drop_sum + DROP_W'(dropped[i]);
    end
  end

  // Saturating dropped-pulse statistic; clear leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else begin
      drop_count <= sat_add(drop_count, drop_sum);
    end
  end

endmodule
